mem_arbiter: RTL and testbench

Arbitrates the single shared multi-cycle main memory between the I-cache and D-cache miss/write interfaces. Grants the memory to one cache for the whole of its busy period (block fill or write), drives the memory control from the owner, and routes returning read data to the owner via an in-flight read tracker. Sits between the two cache instances and the memory module at the top level.

---
 rtl/mem_arbiter_if.sv | 40 ++++
 rtl/mem_arbiter.sv | 55 +++++
 tb/tb_mem_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: cache request/grant, memory control and read-return signals; slave = arbiter, master = caches + memory
interface mem_arbiter_if;
  logic        icache_CacheBusy;
  logic        icache_MemRead;
  logic [15:0] icache_mem_addr;
  logic        dcache_CacheBusy;
  logic        dcache_MemRead;
  logic        dcache_MemWrite;
  logic [15:0] dcache_mem_addr;
  logic [15:0] dcache_mem_write_data;
  logic        MemDataValid;
  logic [15:0] mem_read_data;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_data_in;
  logic        icache_grant;
  logic        dcache_grant;
  logic        icache_MemDataValid;
  logic        dcache_MemDataValid;
  logic [15:0] icache_mem_read_data;
  logic [15:0] dcache_mem_read_data;
  logic        proto_err;
  modport slave (
    input  icache_CacheBusy, icache_MemRead, icache_mem_addr,
    input  dcache_CacheBusy, dcache_MemRead, dcache_MemWrite, dcache_mem_addr, dcache_mem_write_data,
    input  MemDataValid, mem_read_data,
    output mem_enable, mem_wr, mem_addr, mem_data_in,
    output icache_grant, dcache_grant, icache_MemDataValid, dcache_MemDataValid,
    output icache_mem_read_data, dcache_mem_read_data, proto_err
  );
  modport master (
    output icache_CacheBusy, icache_MemRead, icache_mem_addr,
    output dcache_CacheBusy, dcache_MemRead, dcache_MemWrite, dcache_mem_addr, dcache_mem_write_data,
    output MemDataValid, mem_read_data,
    input  mem_enable, mem_wr, mem_addr, mem_data_in,
    input  icache_grant, dcache_grant, icache_MemDataValid, dcache_MemDataValid,
    input  icache_mem_read_data, dcache_mem_read_data, proto_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants shared memory to I/D cache per busy period, drives memory from owner, routes read returns via MEM_LAT-deep tracker; ports clk, rst (async high), bus (mem_arbiter_if.slave)
module mem_arbiter #(
  parameter int MEM_LAT = 4
) (
  input logic clk,
  input logic rst,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, OWN_I, OWN_D, DRAIN} state_t;
  state_t state, state_n, arb;
  logic last_d;
  logic rd;
  logic drain_done;
  logic [MEM_LAT-1:0] trk_v, trk_o;
  always_comb arb = bus.icache_CacheBusy && bus.dcache_CacheBusy ? (last_d ? OWN_I : OWN_D) :
                    bus.icache_CacheBusy ? OWN_I : bus.dcache_CacheBusy ? OWN_D : IDLE;
  assign drain_done = ~|trk_v[MEM_LAT-2:0];
  always_comb state_n = state == IDLE  ? arb :
                        state == OWN_I ? (bus.icache_CacheBusy ? OWN_I : DRAIN) :
                        state == OWN_D ? (bus.dcache_CacheBusy ? OWN_D : DRAIN) :
                        drain_done ? arb : DRAIN;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state            <= IDLE;
      last_d           <= 1'b0;
      bus.icache_grant <= 1'b0;
      bus.dcache_grant <= 1'b0;
    end else begin
      state            <= state_n;
      bus.icache_grant <= state_n == OWN_I;
      bus.dcache_grant <= state_n == OWN_D;
      if (state_n == DRAIN && state != DRAIN) last_d <= state == OWN_D;
    end
  assign bus.mem_enable  = state == OWN_I ? bus.icache_MemRead :
                           state == OWN_D ? bus.dcache_MemRead | bus.dcache_MemWrite : 1'b0;
  assign bus.mem_wr      = state == OWN_D && bus.dcache_MemWrite;
  assign bus.mem_addr    = state == OWN_I ? bus.icache_mem_addr :
                           state == OWN_D ? bus.dcache_mem_addr : 16'h0;
  assign bus.mem_data_in = state == OWN_D ? bus.dcache_mem_write_data : 16'h0;
  assign rd = bus.mem_enable & ~bus.mem_wr;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      trk_v         <= '0;
      trk_o         <= '0;
      bus.proto_err <= 1'b0;
    end else begin
      trk_v         <= {trk_v[MEM_LAT-2:0], rd};
      trk_o         <= {trk_o[MEM_LAT-2:0], state == OWN_D};
      bus.proto_err <= bus.proto_err | (bus.MemDataValid != trk_v[MEM_LAT-1]);
    end
  assign bus.icache_MemDataValid  = bus.MemDataValid & trk_v[MEM_LAT-1] & ~trk_o[MEM_LAT-1];
  assign bus.dcache_MemDataValid  = bus.MemDataValid & trk_v[MEM_LAT-1] & trk_o[MEM_LAT-1];
  assign bus.icache_mem_read_data = bus.mem_read_data;
  assign bus.dcache_mem_read_data = bus.mem_read_data;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter with a fixed-latency memory model
module tb_mem_arbiter;
  localparam int L = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mem_arbiter_if bus();
  mem_arbiter #(.MEM_LAT(L)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic        own_d;
    logic [15:0] data;
    int          at;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic spur = 1'b0;
  logic [L-1:0] pv;
  logic [L-1:0][15:0] pd;
  always @(posedge clk or posedge rst)
    if (rst) begin
      pv <= '0;
      pd <= '0;
    end else begin
      pv <= {pv[L-2:0], bus.mem_enable & ~bus.mem_wr};
      pd <= {pd[L-2:0], (bus.mem_addr >> 1) - 16'd1};
    end
  assign bus.MemDataValid  = pv[L-1] | spur;
  assign bus.mem_read_data = pd[L-1];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic mon();
    exp_t e;
    logic [1:0] v;
    v = {bus.icache_MemDataValid, bus.dcache_MemDataValid};
    if (v != 2'b00) begin
      if (sb.size() == 0) chk("unexpected_valid", {30'd0, v}, 32'd0);
      else begin
        e = sb.pop_front();
        chk("rt_owner", {30'd0, v}, e.own_d ? 32'd1 : 32'd2);
        chk("rt_data", {16'd0, bus.icache_mem_read_data}, {16'd0, e.data});
        chk("rt_dcache_data", {16'd0, bus.dcache_mem_read_data}, {16'd0, e.data});
        chk("rt_cycle", cyc, e.at);
      end
    end
    if (sb.size() > 0 && sb[0].at < cyc) begin
      chk("rt_missing", cyc, sb[0].at);
      void'(sb.pop_front());
    end
  endtask
  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    cyc++;
    #1;
  endtask
  task automatic rd(input logic own_d, input logic [15:0] a);
    sb.push_back('{own_d, (a >> 1) - 16'd1, cyc + L});
  endtask
  task automatic idle_inputs();
    bus.icache_CacheBusy      = 1'b0;
    bus.icache_MemRead        = 1'b0;
    bus.icache_mem_addr       = 16'h0;
    bus.dcache_CacheBusy      = 1'b0;
    bus.dcache_MemRead        = 1'b0;
    bus.dcache_MemWrite       = 1'b0;
    bus.dcache_mem_addr       = 16'h0;
    bus.dcache_mem_write_data = 16'h0;
  endtask
  task automatic chk_reset(input string tag);
    #1;
    chk({tag, "_igrant"}, bus.icache_grant, 0);
    chk({tag, "_dgrant"}, bus.dcache_grant, 0);
    chk({tag, "_en"}, bus.mem_enable, 0);
    chk({tag, "_wr"}, bus.mem_wr, 0);
    chk({tag, "_addr"}, bus.mem_addr, 0);
    chk({tag, "_wdata"}, bus.mem_data_in, 0);
    chk({tag, "_valids"}, {bus.icache_MemDataValid, bus.dcache_MemDataValid}, 0);
    chk({tag, "_perr"}, bus.proto_err, 0);
  endtask
  task automatic fill_i();
    logic [15:0] a;
    bus.icache_CacheBusy = 1'b1;
    #1 chk("i_grant_before", bus.icache_grant, 0);
    tick();
    chk("i_grant", bus.icache_grant, 1);
    chk("i_dgrant", bus.dcache_grant, 0);
    for (int k = 0; k < 8; k++) begin
      a = 16'(4 + 2 * k);
      bus.icache_MemRead  = 1'b1;
      bus.icache_mem_addr = a;
      rd(1'b0, a);
      #1;
      chk("i_en", bus.mem_enable, 1);
      chk("i_wr", bus.mem_wr, 0);
      chk("i_addr", bus.mem_addr, a);
      tick();
    end
    bus.icache_MemRead   = 1'b0;
    bus.icache_CacheBusy = 1'b0;
    tick();
    chk("i_drain_grant", bus.icache_grant, 0);
  endtask
  initial begin
    idle_inputs();
    tick();
    chk_reset("rst");
    rst = 1'b0;
    tick();
    fill_i();
    tick();
    tick();
    bus.dcache_CacheBusy = 1'b1;
    #1 chk("d_grant_last_return", bus.dcache_grant, 0);
    tick();
    chk("d_grant_after_drain", bus.dcache_grant, 1);
    chk("fill_sb_empty", sb.size(), 0);
    bus.dcache_MemWrite       = 1'b1;
    bus.dcache_MemRead        = 1'b1;
    bus.dcache_mem_addr       = 16'h0040;
    bus.dcache_mem_write_data = 16'h1234;
    #1;
    chk("w_en", bus.mem_enable, 1);
    chk("w_wr", bus.mem_wr, 1);
    chk("w_addr", bus.mem_addr, 16'h0040);
    chk("w_data", bus.mem_data_in, 16'h1234);
    tick();
    bus.dcache_MemWrite  = 1'b0;
    bus.dcache_MemRead   = 1'b0;
    bus.dcache_CacheBusy = 1'b0;
    bus.icache_CacheBusy = 1'b1;
    #1 chk("w_grant_holds", bus.dcache_grant, 1);
    chk("w_en_off", bus.mem_enable, 0);
    tick();
    bus.icache_MemRead = 1'b1;
    #1;
    chk("w_drain_dgrant", bus.dcache_grant, 0);
    chk("w_drain_igrant", bus.icache_grant, 0);
    chk("w_drain_en", bus.mem_enable, 0);
    chk("w_drain_addr", bus.mem_addr, 0);
    bus.icache_MemRead = 1'b0;
    tick();
    chk("i_after_write_drain", bus.icache_grant, 1);
    bus.icache_CacheBusy = 1'b0;
    tick();
    bus.icache_CacheBusy = 1'b1;
    bus.dcache_CacheBusy = 1'b1;
    #1 chk("tie1_drain", bus.icache_grant, 0);
    tick();
    chk("tie1_dgrant", bus.dcache_grant, 1);
    chk("tie1_igrant", bus.icache_grant, 0);
    idle_inputs();
    tick();
    tick();
    rst = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0;
    tick();
    bus.icache_CacheBusy = 1'b1;
    bus.dcache_CacheBusy = 1'b1;
    tick();
    chk("tie0_dgrant", bus.dcache_grant, 1);
    chk("tie0_igrant", bus.icache_grant, 0);
    for (int k = 0; k < 3; k++) begin
      bus.dcache_MemRead  = 1'b1;
      bus.dcache_mem_addr = 16'(16'h0100 + 2 * k);
      rd(1'b1, bus.dcache_mem_addr);
      tick();
    end
    bus.dcache_MemRead   = 1'b0;
    bus.dcache_CacheBusy = 1'b0;
    #1 chk("d_owner_while_busy_low", bus.dcache_grant, 1);
    tick();
    bus.dcache_MemRead = 1'b1;
    #1 chk("drain_no_forward", bus.mem_enable, 0);
    bus.dcache_MemRead = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("i_wait_drain", bus.icache_grant, 0);
      tick();
    end
    chk("i_grant_after_3rd", bus.icache_grant, 1);
    chk("drain_sb_empty", sb.size(), 0);
    bus.icache_CacheBusy = 1'b0;
    bus.dcache_CacheBusy = 1'b1;
    tick();
    bus.icache_CacheBusy = 1'b1;
    #1 chk("tie2_drain", bus.dcache_grant, 0);
    tick();
    chk("tie2_dgrant", bus.dcache_grant, 1);
    chk("tie2_igrant", bus.icache_grant, 0);
    idle_inputs();
    tick();
    tick();
    spur = 1'b1;
    #1;
    chk("spur_perr_pre", bus.proto_err, 0);
    chk("spur_routed", {bus.icache_MemDataValid, bus.dcache_MemDataValid}, 0);
    tick();
    spur = 1'b0;
    chk("spur_perr_set", bus.proto_err, 1);
    tick();
    tick();
    tick();
    chk("spur_perr_sticky", bus.proto_err, 1);
    rst = 1'b1;
    tick();
    chk("perr_cleared", bus.proto_err, 0);
    rst = 1'b0;
    tick();
    bus.icache_CacheBusy = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      bus.icache_MemRead  = 1'b1;
      bus.icache_mem_addr = 16'(16'h0200 + 2 * k);
      tick();
    end
    rst = 1'b1;
    chk_reset("midrst");
    idle_inputs();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    chk("midrst_perr", bus.proto_err, 0);
    fill_i();
    for (int k = 0; k < 4; k++) tick();
    chk("final_sb_empty", sb.size(), 0);
    chk("final_perr", bus.proto_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
